// File: rtl/surf_cin_pkg.sv
// Shared types and constants for the SURF command-in (CIN) framer.
package surf_cin_pkg;

  typedef enum logic [1:0] {
    WAIT_SYNC = 2'd0,
    TRAIN     = 2'd1,
    RUN       = 2'd2
  } cin_state_e;

  // Nibbles per 32-bit command word.
  localparam int          CIN_NIBBLES       = 8;
  localparam logic [31:0] CIN_TRAIN_PATTERN = 32'hA55A6996;
  localparam logic [31:0] CIN_IDLE_WORD     = 32'h00000000;

endpackage

// File: rtl/surf_cin_framer.sv
// CIN framer: serialises 32-bit command words MSB-nibble-first, one frame
// per 8 sysclk cycles, aligned to the global sync, with a training mode.
module surf_cin_framer
  import surf_cin_pkg::*;
#(
  parameter bit          CIN_INV       = 1'b0,
  parameter logic [31:0] TRAIN_PATTERN = CIN_TRAIN_PATTERN,
  parameter logic [31:0] IDLE_WORD     = CIN_IDLE_WORD
) (
  input  logic        sysclk_i,
  input  logic        rst_n_i,
  input  logic        sync_i,
  input  logic        train_enable_i,
  input  logic [31:0] cmd_data_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  output logic [3:0]  cin_o,
  output logic        frame_o,
  output logic        running_o,
  output logic        sync_err_o
);

  localparam int            PW     = $clog2(CIN_NIBBLES);
  localparam logic [PW-1:0] P_LAST = PW'(CIN_NIBBLES - 1);

  logic [PW-1:0] p;
  cin_state_e    state, state_nxt;
  logic [31:0]   shreg;
  logic [31:0]   hold_word;
  logic          hold_valid;
  logic [31:0]   load_word;
  logic          load;
  logic          take_hold;
  logic          accept;

  // A load edge is wherever p returns to 0: natural wrap or a sync.
  assign load   = sync_i || (p == P_LAST);
  assign accept = cmd_valid_i && cmd_ready_o;

  // Phase counter: free-running, forced to 0 by sync.
  always_ff @(posedge sysclk_i or negedge rst_n_i) begin
    if (!rst_n_i)    p <= '0;
    else if (sync_i) p <= '0;
    else             p <= p + 1'b1;
  end

  // State register.
  always_ff @(posedge sysclk_i or negedge rst_n_i) begin
    if (!rst_n_i) state <= WAIT_SYNC;
    else          state <= state_nxt;
  end

  // Next state: mode changes only on load edges so words never split.
  always_comb begin
    state_nxt = state;
    case (state)
      WAIT_SYNC: if (sync_i) state_nxt = train_enable_i ? TRAIN : RUN;
      TRAIN:     if (load && !train_enable_i) state_nxt = RUN;
      RUN:       if (load && train_enable_i) state_nxt = TRAIN;
      default:   state_nxt = WAIT_SYNC;
    endcase
  end

  // Outputs decoded from state, phase and hold occupancy.
  always_comb begin
    running_o   = (state != WAIT_SYNC);
    cmd_ready_o = !hold_valid && (state == RUN);
    frame_o     = (p == '0) && (state != WAIT_SYNC);
  end

  // Word for the coming frame, chosen by the mode being entered.
  always_comb begin
    load_word = '0;
    take_hold = 1'b0;
    case (state_nxt)
      TRAIN: load_word = TRAIN_PATTERN;
      RUN: begin
        if (hold_valid) begin
          load_word = hold_word;
          take_hold = load;
        end else begin
          load_word = IDLE_WORD;
        end
      end
      default: load_word = '0;
    endcase
  end

  // Shift register: load at frame start, otherwise shift out one nibble.
  always_ff @(posedge sysclk_i or negedge rst_n_i) begin
    if (!rst_n_i)  shreg <= '0;
    else if (load) shreg <= load_word;
    else           shreg <= {shreg[27:0], 4'h0};
  end

  // One-deep hold register; survives TRAIN intervals, drained only by a RUN load.
  // Accept and drain are exclusive: accept needs the register empty.
  always_ff @(posedge sysclk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      hold_valid <= 1'b0;
      hold_word  <= '0;
    end else if (take_hold) begin
      hold_valid <= 1'b0;
    end else if (accept) begin
      hold_valid <= 1'b1;
      hold_word  <= cmd_data_i;
    end
  end

  // Flag a sync that truncates a running frame.
  always_ff @(posedge sysclk_i or negedge rst_n_i) begin
    if (!rst_n_i) sync_err_o <= 1'b0;
    else          sync_err_o <= sync_i && (state != WAIT_SYNC) && (p != P_LAST);
  end

  assign cin_o = shreg[31:28] ^ {4{CIN_INV}};

endmodule

// File: tb/tb_surf_cin_framer.sv
// Bench for surf_cin_framer: vector table for train/run framing, hand
// sequences for command latency, mode toggles, sync errors and reset, plus
// a scoreboard matching every command word seen on cin against what was sent.
module tb_surf_cin_framer;

  logic        clk;
  logic        rst_n;
  logic        sync;
  logic        train;
  logic [31:0] cmd_data;
  logic        cmd_valid;

  logic        ready, frame, running, err;
  logic [3:0]  cin;
  logic        ready_x, frame_x, running_x, err_x;
  logic [3:0]  cin_x;

  surf_cin_framer #(.CIN_INV(1'b0)) dut (
    .sysclk_i(clk), .rst_n_i(rst_n), .sync_i(sync), .train_enable_i(train),
    .cmd_data_i(cmd_data), .cmd_valid_i(cmd_valid), .cmd_ready_o(ready),
    .cin_o(cin), .frame_o(frame), .running_o(running), .sync_err_o(err)
  );

  surf_cin_framer #(.CIN_INV(1'b1)) dut_inv (
    .sysclk_i(clk), .rst_n_i(rst_n), .sync_i(sync), .train_enable_i(train),
    .cmd_data_i(cmd_data), .cmd_valid_i(cmd_valid), .cmd_ready_o(ready_x),
    .cin_o(cin_x), .frame_o(frame_x), .running_o(running_x), .sync_err_o(err_x)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int ph     = 0;
  logic [31:0] sb_q[$];

  typedef struct {
    logic       sync;
    logic       train;
    logic [3:0] cin;
    logic       frame;
    logic       ready;
  } vec_t;

  vec_t       tbl[32];
  logic [3:0] tp_nib[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, required %h", nm, act, exp);
  endtask

  // One clock; ph mirrors the expected phase after the edge.
  task automatic tick();
    logic s;
    s = sync;
    @(posedge clk);
    #1;
    if (!rst_n || s) ph = 0;
    else             ph = (ph + 1) % 8;
  endtask

  task automatic go_phase(input int k);
    int n;
    n = 0;
    while (ph != k && n < 16) begin
      tick();
      n++;
    end
    if (ph != k) begin
      n_chk++;
      $display("FAIL go_phase timeout: phase %0d, required %0d", ph, k);
    end
  endtask

  // Scoreboard monitor: assemble each full frame; non-idle, non-train words
  // must match the oldest outstanding command.
  initial begin
    logic [31:0] w;
    int          cnt;
    cnt = -1;
    w   = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        cnt = -1;
      end else if (frame) begin
        w   = {28'h0, cin};
        cnt = 1;
      end else if (cnt > 0) begin
        w   = {w[27:0], cin};
        cnt++;
      end
      if (cnt == 8) begin
        if (w != 32'h0 && w != 32'hA55A6996) begin
          if (sb_q.size() == 0) begin
            n_chk++;
            $display("FAIL sb_unexpected: got %h, required no command", w);
          end else begin
            chk("sb_word", w, sb_q.pop_front());
          end
        end
        cnt = -1;
      end
    end
  end

  initial begin
    logic [31:0] w;
    int          acc;
    logic        got;
    logic        bad;

    tp_nib[0] = 4'hA; tp_nib[1] = 4'h5; tp_nib[2] = 4'h5; tp_nib[3] = 4'hA;
    tp_nib[4] = 4'h6; tp_nib[5] = 4'h9; tp_nib[6] = 4'h9; tp_nib[7] = 4'h6;
    // Two train frames, a third where the request drops at phase 3, then an
    // idle RUN frame ending in an on-boundary sync.
    for (int i = 0; i < 32; i++) begin
      tbl[i].sync  = (i == 31);
      tbl[i].train = (i < 19);
      tbl[i].cin   = (i < 24) ? tp_nib[i % 8] : 4'h0;
      tbl[i].frame = ((i % 8) == 0);
      tbl[i].ready = (i >= 24);
    end

    rst_n = 1'b0; sync = 1'b0; train = 1'b0; cmd_valid = 1'b0; cmd_data = '0;
    #3;
    chk("rst_cin", {28'h0, cin}, 32'h0);
    chk("rst_cin_inv", {28'h0, cin_x}, 32'hF);
    chk("rst_flags", {28'h0, frame, ready, running, err}, 32'h0);
    tick(); tick();
    rst_n = 1'b1;
    repeat (10) tick();
    chk("presync_flags", {28'h0, frame, ready, running, err}, 32'h0);
    chk("presync_cin", {24'h0, cin, cin_x}, 32'h0F);

    // Enter TRAIN via sync
    train = 1'b1; sync = 1'b1;
    tick();
    sync = 1'b0;
    for (int i = 0; i < 32; i++) begin
      sync  = tbl[i].sync;
      train = tbl[i].train;
      chk($sformatf("tbl%0d_cin", i), {28'h0, cin}, {28'h0, tbl[i].cin});
      chk($sformatf("tbl%0d_cin_inv", i), {28'h0, cin_x}, {28'h0, ~tbl[i].cin});
      chk($sformatf("tbl%0d_frame", i), {31'h0, frame}, {31'h0, tbl[i].frame});
      chk($sformatf("tbl%0d_ready", i), {31'h0, ready}, {31'h0, tbl[i].ready});
      chk($sformatf("tbl%0d_run_err", i), {30'h0, running, err}, 32'h2);
      tick();
    end
    sync = 1'b0;
    chk("sync_p7_err", {31'h0, err}, 32'h0);
    chk("sync_p7_frame", {31'h0, frame}, 32'h1);

    // Single command offered mid-frame
    go_phase(3);
    cmd_valid = 1'b1; cmd_data = 32'h12345678;
    chk("cmd_ready_before", {31'h0, ready}, 32'h1);
    sb_q.push_back(cmd_data);
    tick();
    cmd_valid = 1'b0;
    chk("cmd_ready_drop", {31'h0, ready}, 32'h0);
    go_phase(0);
    chk("cmd_ready_return", {31'h0, ready}, 32'h1);
    chk("cmd_frame", {31'h0, frame}, 32'h1);
    w = {28'h0, cin};
    for (int k = 1; k < 8; k++) begin
      tick();
      w = {w[27:0], cin};
    end
    chk("cmd_word", w, 32'h12345678);
    tick();
    w = {28'h0, cin};
    for (int k = 1; k < 8; k++) begin
      tick();
      w = {w[27:0], cin};
    end
    chk("idle_after_cmd", w, 32'h0);

    // Back-to-back with valid held high
    go_phase(0);
    acc = 0;
    cmd_valid = 1'b1;
    cmd_data = 32'hC0000000 | ($urandom & 32'h0FFFFFFF);
    for (int c = 0; c < 48; c++) begin
      got = 1'b0;
      if (ready) begin
        sb_q.push_back(cmd_data);
        acc++;
        got = 1'b1;
      end
      tick();
      if (got) cmd_data = 32'hC0000000 | ($urandom & 32'h0FFFFFFF);
    end
    cmd_valid = 1'b0;
    repeat (16) tick();
    chk("b2b_accepts", acc, 32'd6);
    chk("b2b_drained", sb_q.size(), 32'd0);

    // Held command survives a TRAIN interval
    go_phase(2);
    cmd_valid = 1'b1; cmd_data = 32'hBEEF1234;
    sb_q.push_back(cmd_data);
    tick();
    cmd_valid = 1'b0;
    go_phase(4);
    train = 1'b1;
    go_phase(7);
    chk("toggle_still_run", {28'h0, cin}, 32'h0);
    go_phase(0);
    chk("toggle_train_cin", {28'h0, cin}, 32'hA);
    chk("toggle_train_ready", {31'h0, ready}, 32'h0);
    go_phase(5);
    train = 1'b0;
    go_phase(7);
    chk("toggle_train_tail", {28'h0, cin}, 32'h6);
    go_phase(0);
    chk("toggle_held_cin", {28'h0, cin}, 32'hB);
    chk("toggle_held_ready", {31'h0, ready}, 32'h1);
    go_phase(1);
    chk("toggle_held_cin1", {28'h0, cin}, 32'hE);

    // Off-boundary sync
    go_phase(3);
    sync = 1'b1;
    tick();
    sync = 1'b0;
    chk("serr_pulse", {31'h0, err}, 32'h1);
    chk("serr_frame", {31'h0, frame}, 32'h1);
    tick();
    chk("serr_once", {31'h0, err}, 32'h0);
    go_phase(7);
    sync = 1'b1;
    tick();
    sync = 1'b0;
    chk("clean_sync_err", {31'h0, err}, 32'h0);
    chk("clean_sync_frame", {31'h0, frame}, 32'h1);

    // Reset in the middle of a command frame
    go_phase(1);
    cmd_valid = 1'b1; cmd_data = 32'h76543210;
    sb_q.push_back(cmd_data);
    tick();
    cmd_valid = 1'b0;
    go_phase(0);
    chk("rstmid_cin0", {24'h0, cin, cin_x}, 32'h78);
    go_phase(2);
    chk("rstmid_cin2", {28'h0, cin}, 32'h5);
    #2;
    rst_n = 1'b0;
    sb_q.delete();
    #1;
    chk("rstmid_cin_inv", {28'h0, cin_x}, 32'hF);
    chk("rstmid_cin", {28'h0, cin}, 32'h0);
    chk("rstmid_flags", {28'h0, frame, ready, running, err}, 32'h0);
    chk("rstmid_ready_inv", {31'h0, ready_x}, 32'h0);
    tick(); tick();
    rst_n = 1'b1;
    bad = 1'b0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (running || ready || frame || cin_x != 4'hF || running_x) bad = 1'b1;
    end
    chk("post_rst_idle", {31'h0, bad}, 32'h0);
    train = 1'b0; sync = 1'b1;
    tick();
    sync = 1'b0;
    chk("resume_flags", {28'h0, frame, ready, running, err}, 32'hE);
    chk("resume_cin_inv", {28'h0, cin_x}, 32'hF);

    repeat (10) tick();
    chk("sb_empty", sb_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
